dip_cfg_store: RTL and testbench

DIP_CFG_STORE -- requirements
Module: dip_cfg_store

---
 rtl/cfg_pkg.sv | 25 ++
 rtl/cfg_bank.sv | 40 ++++
 rtl/dip_cfg_store.sv | 159 +++++++++++++++
 tb/tb_dip_cfg_store.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared types and constants for the DIP config store.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cfg_pkg;

    // Number of config bytes held by each bank.
    localparam int CFG_DEPTH = 8;

    // Value returned for reads beyond the config byte range.
    localparam logic [7:0] CFG_OOR_DAT = 8'hFF;

    // Load FSM: collect a download into the shadow bank, then commit it.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } ld_state_t;

    // Read FSM: one stall cycle per upload read strobe.
    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/cfg_bank.sv
// Byte bank with one write port, a whole-bank copy-in and a combinational read port.
// Latency: writes/copies visible the cycle after the strobe; reads are combinational.
// Backpressure: none; copy-in wins over a same-cycle byte write.
module cfg_bank
    import cfg_pkg::*;
#(
    parameter int         DEPTH = CFG_DEPTH,
    parameter logic [7:0] RST0  = 8'h00,
    parameter int         AW    = $clog2(DEPTH)
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [7:0]            wr_dat,
    input  logic                  cpy_en,
    input  logic [DEPTH-1:0][7:0] cpy_dat,
    input  logic [AW-1:0]         rd_addr,
    output logic [7:0]            rd_dat,
    output logic [DEPTH-1:0][7:0] bank_dat
);

    logic [DEPTH-1:0][7:0] mem_q;

    // Byte storage: reset to RST0 in byte 0, zeros elsewhere; bulk copy has priority.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            mem_q[0] <= RST0;
        end else if (cpy_en) begin
            mem_q <= cpy_dat;
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat   = mem_q[rd_addr];
    assign bank_dat = mem_q;

endmodule

// File: rtl/dip_cfg_store.sv
// DIP switch config store loaded/read over the HPS ioctl bus with atomic commit.
// Latency: sw updates the cycle after COMMIT; read data lands one cycle after the strobe.
// Backpressure: ioctl_wait stalls the host for one cycle per read; downloads never stall.
module dip_cfg_store
    import cfg_pkg::*;
#(
    parameter int         INDEX   = 254,
    parameter int         DEPTH   = CFG_DEPTH,
    parameter logic [7:0] DEF_SW0 = 8'h00
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_upload,
    input  logic [15:0] ioctl_index,
    input  logic [26:0] ioctl_addr,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ioctl_rd,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    output logic [7:0]  sw,
    output logic        cfg_valid,
    output logic        cfg_changed
);

    ld_state_t ld_q, ld_d;
    rd_state_t rd_q, rd_d;

    logic                  idx_hit;
    logic                  addr_in_rng;
    logic                  sh_wr, sh_cpy, act_cpy, rd_go;
    logic [DEPTH-1:0][7:0] sh_bytes, act_bytes;
    logic [7:0]            act_rd_dat, sh_rd_unused;
    logic [2:0]            rd_addr_q;
    logic                  rd_oor_q;
    logic                  addr_hi_unused;

    assign idx_hit        = (ioctl_index == 16'(INDEX));
    assign addr_in_rng    = (ioctl_addr[24:3] == '0);
    assign addr_hi_unused = ^ioctl_addr[26:25];

    // Shadow bank: seeded from active on session start, filled by download writes.
    cfg_bank #(.DEPTH(DEPTH), .RST0(8'h00)) u_shadow (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .wr_en    (sh_wr),
        .wr_addr  (ioctl_addr[2:0]),
        .wr_dat   (ioctl_dout),
        .cpy_en   (sh_cpy),
        .cpy_dat  (act_bytes),
        .rd_addr  (3'd0),
        .rd_dat   (sh_rd_unused),
        .bank_dat (sh_bytes)
    );

    // Active bank: only ever changed by a whole-bank commit, so sw flips atomically.
    cfg_bank #(.DEPTH(DEPTH), .RST0(DEF_SW0)) u_active (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .wr_en    (1'b0),
        .wr_addr  (3'd0),
        .wr_dat   (8'h00),
        .cpy_en   (act_cpy),
        .cpy_dat  (sh_bytes),
        .rd_addr  (rd_addr_q),
        .rd_dat   (act_rd_dat),
        .bank_dat (act_bytes)
    );

    assign sw = act_bytes[0];

    // Load FSM next-state and bank strobes; the write on the falling-edge cycle still lands.
    always_comb begin
        ld_d    = ld_q;
        sh_wr   = 1'b0;
        sh_cpy  = 1'b0;
        act_cpy = 1'b0;
        case (ld_q)
            IDLE: begin
                if (ioctl_download && idx_hit) begin
                    ld_d   = LOAD;
                    sh_cpy = 1'b1;
                end
            end
            LOAD: begin
                sh_wr = ioctl_wr && addr_in_rng;
                if (!ioctl_download) begin
                    ld_d = COMMIT;
                end
            end
            COMMIT: begin
                act_cpy = 1'b1;
                ld_d    = IDLE;
            end
            default: ld_d = IDLE;
        endcase
    end

    // Load FSM state register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ld_q <= IDLE;
        end else begin
            ld_q <= ld_d;
        end
    end

    // Commit status: valid sticks after the first commit, changed pulses with the new sw.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cfg_valid   <= 1'b0;
            cfg_changed <= 1'b0;
        end else begin
            cfg_changed <= act_cpy && (sh_bytes != act_bytes);
            if (act_cpy) begin
                cfg_valid <= 1'b1;
            end
        end
    end

    // Read FSM next-state; an active download masks read strobes entirely.
    always_comb begin
        rd_d  = rd_q;
        rd_go = 1'b0;
        case (rd_q)
            RD_IDLE: begin
                if (ioctl_rd && ioctl_upload && !ioctl_download && idx_hit) begin
                    rd_d  = RD_DATA;
                    rd_go = 1'b1;
                end
            end
            RD_DATA: rd_d = RD_IDLE;
            default: rd_d = RD_IDLE;
        endcase
    end

    // Read state, captured address and held read data.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rd_q      <= RD_IDLE;
            rd_addr_q <= 3'd0;
            rd_oor_q  <= 1'b0;
            ioctl_din <= 8'h00;
        end else begin
            rd_q <= rd_d;
            if (rd_go) begin
                rd_addr_q <= ioctl_addr[2:0];
                rd_oor_q  <= !addr_in_rng;
            end
            if (rd_q == RD_DATA) begin
                ioctl_din <= rd_oor_q ? CFG_OOR_DAT : act_rd_dat;
            end
        end
    end

    assign ioctl_wait = (rd_q == RD_DATA);

endmodule

// File: tb/tb_dip_cfg_store.sv
// Directed bench for dip_cfg_store: vector table plus hand-written reset/commit sequences.
// Latency: each vector is one clock; outputs are compared 1 ns after the rising edge.
// Backpressure: n/a.
module tb_dip_cfg_store;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download, ioctl_upload, ioctl_wr, ioctl_rd;
    logic [15:0] ioctl_index;
    logic [26:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic [7:0]  sw;
    logic        cfg_valid, cfg_changed;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    dip_cfg_store #(.INDEX(254), .DEPTH(8), .DEF_SW0(8'h05)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_upload   (ioctl_upload),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_wr       (ioctl_wr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_rd       (ioctl_rd),
        .ioctl_din      (ioctl_din),
        .ioctl_wait     (ioctl_wait),
        .sw             (sw),
        .cfg_valid      (cfg_valid),
        .cfg_changed    (cfg_changed)
    );

    typedef struct {
        logic        dl, up;
        logic [15:0] idx;
        logic [26:0] addr;
        logic        wr;
        logic [7:0]  dout;
        logic        rd;
        logic [7:0]  e_sw;
        logic        e_v, e_c, e_w;
        logic [7:0]  e_din;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int dl, int up, int idx, int addr, int wr, int dout, int rd,
                                int e_sw, int e_v, int e_c, int e_w, int e_din);
        vec_t v;
        v.dl    = 1'(dl);
        v.up    = 1'(up);
        v.idx   = 16'(idx);
        v.addr  = 27'(addr);
        v.wr    = 1'(wr);
        v.dout  = 8'(dout);
        v.rd    = 1'(rd);
        v.e_sw  = 8'(e_sw);
        v.e_v   = 1'(e_v);
        v.e_c   = 1'(e_c);
        v.e_w   = 1'(e_w);
        v.e_din = 8'(e_din);
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_sw, input logic e_v,
                             input logic e_c, input logic e_w, input logic [7:0] e_din);
        check($sformatf("%s sw", tag), sw, e_sw);
        check($sformatf("%s cfg_valid", tag), {7'd0, cfg_valid}, {7'd0, e_v});
        check($sformatf("%s cfg_changed", tag), {7'd0, cfg_changed}, {7'd0, e_c});
        check($sformatf("%s ioctl_wait", tag), {7'd0, ioctl_wait}, {7'd0, e_w});
        check($sformatf("%s ioctl_din", tag), ioctl_din, e_din);
    endtask

    // Drive one cycle of inputs, then step to 1 ns past the next rising edge.
    task automatic drive(input logic dl, input logic up, input logic [15:0] idx,
                         input logic [26:0] addr, input logic wr, input logic [7:0] dout,
                         input logic rd);
        ioctl_download = dl;
        ioctl_upload   = up;
        ioctl_index    = idx;
        ioctl_addr     = addr;
        ioctl_wr       = wr;
        ioctl_dout     = dout;
        ioctl_rd       = rd;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'd0, 27'd0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        // First download: two writes, sw must hold 05 until the commit.
        tbl.push_back(mk(1,0,254,0,0,'h00,0, 'h05,0,0,0,'h00));
        tbl.push_back(mk(1,0,254,0,1,'h1E,0, 'h05,0,0,0,'h00));
        tbl.push_back(mk(1,0,254,3,1,'hA5,0, 'h05,0,0,0,'h00));
        tbl.push_back(mk(0,0,254,0,0,'h00,0, 'h05,0,0,0,'h00));
        tbl.push_back(mk(0,0,0,0,0,'h00,0,   'h1E,1,1,0,'h00));
        tbl.push_back(mk(0,0,0,0,0,'h00,0,   'h1E,1,0,0,'h00));
        // Identical download, with out-of-range writes and the last write on the falling edge.
        tbl.push_back(mk(1,0,254,0,0,'h00,0, 'h1E,1,0,0,'h00));
        tbl.push_back(mk(1,0,254,0,1,'h1E,0, 'h1E,1,0,0,'h00));
        tbl.push_back(mk(1,0,254,8,1,'h55,0, 'h1E,1,0,0,'h00));
        tbl.push_back(mk(1,0,254,'h1000000,1,'h66,0, 'h1E,1,0,0,'h00));
        tbl.push_back(mk(0,0,254,3,1,'hA5,0, 'h1E,1,0,0,'h00));
        tbl.push_back(mk(0,0,0,0,0,'h00,0,   'h1E,1,0,0,'h00));
        tbl.push_back(mk(0,0,0,0,0,'h00,0,   'h1E,1,0,0,'h00));
        // Foreign index download: nothing happens.
        tbl.push_back(mk(1,0,0,0,0,'h00,0,   'h1E,1,0,0,'h00));
        tbl.push_back(mk(1,0,0,0,1,'hFF,0,   'h1E,1,0,0,'h00));
        tbl.push_back(mk(0,0,0,0,0,'h00,0,   'h1E,1,0,0,'h00));
        tbl.push_back(mk(0,0,0,0,0,'h00,0,   'h1E,1,0,0,'h00));
        // Upload reads: addr3, then out-of-range addr9.
        tbl.push_back(mk(0,1,254,3,0,'h00,1, 'h1E,1,0,1,'h00));
        tbl.push_back(mk(0,1,254,0,0,'h00,0, 'h1E,1,0,0,'hA5));
        tbl.push_back(mk(0,1,254,9,0,'h00,1, 'h1E,1,0,1,'hA5));
        tbl.push_back(mk(0,1,254,0,0,'h00,0, 'h1E,1,0,0,'hFF));
        tbl.push_back(mk(0,0,0,0,0,'h00,0,   'h1E,1,0,0,'hFF));
        // Strobe during RD_DATA is dropped; wrong-index read is dropped.
        tbl.push_back(mk(0,1,254,0,0,'h00,1, 'h1E,1,0,1,'hFF));
        tbl.push_back(mk(0,1,254,3,0,'h00,1, 'h1E,1,0,0,'h1E));
        tbl.push_back(mk(0,1,254,0,0,'h00,0, 'h1E,1,0,0,'h1E));
        tbl.push_back(mk(0,1,0,3,0,'h00,1,   'h1E,1,0,0,'h1E));
        // Upload and download together: download wins, read ignored.
        tbl.push_back(mk(1,1,254,3,0,'h00,1, 'h1E,1,0,0,'h1E));
        tbl.push_back(mk(0,0,0,0,0,'h00,0,   'h1E,1,0,0,'h1E));
        tbl.push_back(mk(0,0,0,0,0,'h00,0,   'h1E,1,0,0,'h1E));

        reset = 1'b1;
        ioctl_download = 1'b0; ioctl_upload = 1'b0; ioctl_index = 16'd0;
        ioctl_addr = 27'd0; ioctl_wr = 1'b0; ioctl_dout = 8'h00; ioctl_rd = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        check_all("reset", 8'h05, 1'b0, 1'b0, 1'b0, 8'h00);
        reset = 1'b0;
        idle();
        check_all("post_reset", 8'h05, 1'b0, 1'b0, 1'b0, 8'h00);

        foreach (tbl[i]) begin
            drive(tbl[i].dl, tbl[i].up, tbl[i].idx, tbl[i].addr, tbl[i].wr, tbl[i].dout, tbl[i].rd);
            check_all($sformatf("row%0d", i), tbl[i].e_sw, tbl[i].e_v, tbl[i].e_c,
                      tbl[i].e_w, tbl[i].e_din);
        end

        // Write on the same cycle download drops must reach the commit with a new value.
        drive(1'b1, 1'b0, 16'd254, 27'd0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 16'd254, 27'd0, 1'b1, 8'h42, 1'b0);
        check_all("edge_wr commit", 8'h1E, 1'b1, 1'b0, 1'b0, 8'h1E);
        idle();
        check_all("edge_wr applied", 8'h42, 1'b1, 1'b1, 1'b0, 8'h1E);
        idle();
        check("edge_wr pulse_end", {7'd0, cfg_changed}, 8'h00);

        // Reset in the middle of a load drops the shadow and restores defaults.
        drive(1'b1, 1'b0, 16'd254, 27'd0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 16'd254, 27'd0, 1'b1, 8'h77, 1'b0);
        ioctl_wr = 1'b0;
        reset = 1'b1;
        #2;
        check_all("mid_load reset", 8'h05, 1'b0, 1'b0, 1'b0, 8'h00);
        reset = 1'b0;
        drive(1'b1, 1'b0, 16'd254, 27'd0, 1'b0, 8'h00, 1'b0);
        check_all("reload", 8'h05, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 16'd254, 27'd0, 1'b0, 8'h00, 1'b0);
        check_all("reload commit", 8'h05, 1'b0, 1'b0, 1'b0, 8'h00);
        idle();
        check_all("reload applied", 8'h05, 1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 16'd254, 27'd3, 1'b0, 8'h00, 1'b1);
        check_all("post_reset rd3", 8'h05, 1'b1, 1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b1, 16'd254, 27'd0, 1'b0, 8'h00, 1'b0);
        check_all("post_reset rd3 data", 8'h05, 1'b1, 1'b0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
